// File: rtl/seq_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// seq_pkg : state encoding, opcode constants and defaults for cpu_sequencer
// rev 1.0
// ------------------------------------------------------------------------
package seq_pkg;

  localparam int unsigned DEF_PC_W = 4;
  localparam int unsigned DEF_OP_W = 32;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_e;

  function automatic logic [3:0] opcode_of(input logic [31:0] instr);
    return instr[31:28];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pc.sv
`default_nettype none
// ------------------------------------------------------------------------
// seq_pc : program counter with branch load and wrapping increment
// rev 1.0
// ------------------------------------------------------------------------
module seq_pc #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      pc_d = load ? load_val : (pc_q + PC_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// cpu_sequencer : multi-cycle fetch/decode/exec/mem/wb control for 5puzzle
// rev 1.0
// ------------------------------------------------------------------------
module cpu_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int OP_W = DEF_OP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [OP_W-1:0] imem_rdata,
  output logic [OP_W-1:0] op,
  input  logic            dec_pc_we,
  input  logic [3:0]      dec_pc_in,
  input  logic            dec_reg_we,
  input  logic            dec_mem_we,
  output logic            dmem_req,
  input  logic            dmem_ack,
  output logic            reg_we_o,
  output logic            mem_we_o,
  output logic [PC_W-1:0] pc,
  output logic            retire,
  output logic            halted,
  output logic [2:0]      state_o
);

  seq_state_e      state_q, state_d;
  logic            imem_req_q, imem_req_d;
  logic [OP_W-1:0] op_q, op_d;

  logic [3:0] opcode;
  logic       is_alu;
  logic       is_jmp;
  logic       qual_reg_we;
  logic       qual_mem_we;
  logic       qual_pc_we;
  logic       in_wb;

  // Decoder outputs are only meaningful for ALU/JMP; everything else is masked.
  assign opcode      = opcode_of(op_q[31:0]);
  assign is_alu      = (opcode == OP_ALU);
  assign is_jmp      = (opcode == OP_JMP);
  assign qual_reg_we = is_alu & dec_reg_we;
  assign qual_mem_we = is_alu & dec_mem_we;
  assign qual_pc_we  = (is_alu | is_jmp) & dec_pc_we;
  assign in_wb       = (state_q == ST_WB);

  always_comb begin
    state_d    = state_q;
    imem_req_d = 1'b0;
    op_d       = op_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Request rises one cycle after FETCH entry; an ack only counts while it is up.
        imem_req_d = 1'b1;
        if (imem_req_q && imem_ack) begin
          op_d       = imem_rdata;
          imem_req_d = 1'b0;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        state_d = qual_mem_we ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (dmem_ack) state_d = ST_WB;
      end
      ST_WB: begin
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      imem_req_q <= 1'b0;
      op_q       <= '0;
    end else begin
      state_q    <= state_d;
      imem_req_q <= imem_req_d;
      op_q       <= op_d;
    end
  end

  seq_pc #(
    .PC_W (PC_W)
  ) u_seq_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (in_wb),
    .load     (qual_pc_we),
    .load_val (dec_pc_in[PC_W-1:0]),
    .pc       (pc)
  );

  assign imem_req  = imem_req_q;
  assign imem_addr = pc;
  assign op        = op_q;
  assign dmem_req  = (state_q == ST_MEM);
  assign mem_we_o  = (state_q == ST_MEM);
  assign reg_we_o  = in_wb & qual_reg_we;
  assign retire    = in_wb;
  assign halted    = (state_q == ST_HALT);
  assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_cpu_sequencer : randomized bench against a per-instruction phase model
// rev 1.0
// ------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [3:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] op;
  logic        dec_pc_we;
  logic [3:0]  dec_pc_in;
  logic        dec_reg_we;
  logic        dec_mem_we;
  logic        dmem_req;
  logic        dmem_ack;
  logic        reg_we_o;
  logic        mem_we_o;
  logic [3:0]  pc;
  logic        retire;
  logic        halted;
  logic [2:0]  state_o;

  cpu_sequencer #(
    .PC_W (4),
    .OP_W (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .op         (op),
    .dec_pc_we  (dec_pc_we),
    .dec_pc_in  (dec_pc_in),
    .dec_reg_we (dec_reg_we),
    .dec_mem_we (dec_mem_we),
    .dmem_req   (dmem_req),
    .dmem_ack   (dmem_ack),
    .reg_we_o   (reg_we_o),
    .mem_we_o   (mem_we_o),
    .pc         (pc),
    .retire     (retire),
    .halted     (halted),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, written by the stimulus thread.
  logic [2:0]  e_state;
  logic        e_imem_req, e_dmem_req, e_reg_we, e_retire, e_halted;
  logic [3:0]  e_pc;
  logic [31:0] e_op;
  logic        chk_en = 1'b0;

  // Architectural view of the program: memory image, PC and instruction register.
  logic [31:0] imem [16];
  logic [3:0]  m_pc;
  logic [31:0] m_op;

  int cyc = 0;
  int last_retire_cyc = 0;
  int prev_retire_cyc = 0;
  int dmem_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (retire) begin
      prev_retire_cyc = last_retire_cyc;
      last_retire_cyc = cyc;
    end
    if (dmem_req) dmem_cycles++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state_o",   32'(state_o),   32'(e_state));
      check("imem_req",  32'(imem_req),  32'(e_imem_req));
      check("imem_addr", 32'(imem_addr), 32'(e_pc));
      check("pc",        32'(pc),        32'(e_pc));
      check("op",        op,             e_op);
      check("dmem_req",  32'(dmem_req),  32'(e_dmem_req));
      check("mem_we_o",  32'(mem_we_o),  32'(e_dmem_req));
      check("reg_we_o",  32'(reg_we_o),  32'(e_reg_we));
      check("retire",    32'(retire),    32'(e_retire));
      check("halted",    32'(halted),    32'(e_halted));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic [2:0] st, input logic ireq, input logic dreq,
                         input logic rwe, input logic ret, input logic hlt);
    e_state    = st;
    e_imem_req = ireq;
    e_dmem_req = dreq;
    e_reg_we   = rwe;
    e_retire   = ret;
    e_halted   = hlt;
    e_pc       = m_pc;
    e_op       = m_op;
  endtask

  task automatic garbage_dec();
    dec_pc_we  = 1'($urandom);
    dec_pc_in  = 4'($urandom);
    dec_reg_we = 1'($urandom);
    dec_mem_we = 1'($urandom);
  endtask

  // Stand-in decoder: ALU fields come from fixed bits, JMP asserts every request.
  task automatic drive_dec(input logic [31:0] ins);
    case (ins[31:28])
      4'h0: begin
        dec_reg_we = ins[24];
        dec_mem_we = ins[16];
        dec_pc_we  = ins[12];
        dec_pc_in  = ins[3:0];
      end
      4'h1: begin
        dec_reg_we = 1'b1;
        dec_mem_we = 1'b1;
        dec_pc_we  = 1'b1;
        dec_pc_in  = ins[3:0];
      end
      default: garbage_dec();
    endcase
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned sel;
    w   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 4)      w[31:28] = 4'h0;
    else if (sel < 6) w[31:28] = 4'h1;
    else              w[31:28] = 4'($urandom_range(2, 14));
    return w;
  endfunction

  // Entered at the first FETCH cycle; leaves at the cycle after WB (or first HALT cycle).
  task automatic do_instr(input int iw, input int dw, input logic run_wb, output logic hit_halt);
    logic [31:0] ins;
    logic [3:0]  opc;
    hit_halt = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'($urandom);
    run      = 1'($urandom);
    garbage_dec();
    set_exp(S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    ins = imem[m_pc];
    for (int i = 0; i <= iw; i++) begin
      imem_ack   = (i == iw);
      imem_rdata = (i == iw) ? ins : $urandom;
      dmem_ack   = 1'($urandom);
      run        = 1'($urandom);
      garbage_dec();
      set_exp(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    m_op     = ins;
    opc      = ins[31:28];
    imem_ack = 1'($urandom);
    run      = 1'($urandom);
    garbage_dec();
    set_exp(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    if (opc == 4'hF) begin
      hit_halt = 1'b1;
      return;
    end
    drive_dec(ins);
    run = 1'($urandom);
    set_exp(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    if (opc == 4'h0 && ins[16]) begin
      for (int i = 0; i <= dw; i++) begin
        dmem_ack = (i == dw);
        imem_ack = 1'($urandom);
        run      = 1'($urandom);
        drive_dec(ins);
        set_exp(S_MEM, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
      end
    end
    dmem_ack = 1'($urandom);
    imem_ack = 1'($urandom);
    run      = run_wb;
    drive_dec(ins);
    set_exp(S_WB, 1'b0, 1'b0, (opc == 4'h0) && ins[24], 1'b1, 1'b0);
    tick();
    if ((opc == 4'h0 && ins[12]) || opc == 4'h1) m_pc = ins[3:0];
    else                                          m_pc = m_pc + 4'd1;
  endtask

  // Entered in an IDLE cycle; leaves at the first FETCH cycle.
  task automatic idle_until_run(input int n);
    for (int i = 0; i < n; i++) begin
      run      = 1'b0;
      imem_ack = 1'($urandom);
      dmem_ack = 1'($urandom);
      garbage_dec();
      set_exp(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    run = 1'b1;
    set_exp(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc  = 4'd0;
    m_op  = 32'd0;
    set_exp(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
  endtask

  initial begin
    logic h;
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    dmem_ack = 1'b0; dec_pc_we = 1'b0; dec_pc_in = '0; dec_reg_we = 1'b0; dec_mem_we = 1'b0;
    m_pc = 4'd0; m_op = 32'd0;
    for (int a = 0; a < 16; a++) imem[a] = 32'd0;
    imem[0]  = 32'h0120_0000;
    imem[1]  = 32'h0120_0000;
    imem[2]  = 32'h0120_0000;
    imem[3]  = 32'h1000_0009;
    imem[9]  = 32'h0001_0000;
    imem[10] = 32'h1000_000F;
    imem[15] = 32'h2000_0000;

    repeat (2) @(posedge clk);
    #1;
    check("rst_state",    32'(state_o),  32'(S_IDLE));
    check("rst_pc",       32'(pc),       32'd0);
    check("rst_op",       op,            32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_retire",   32'(retire),   32'd0);
    check("rst_halted",   32'(halted),   32'd0);
    rst_n = 1'b1;
    set_exp(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;

    // Reset while the fetch request is up.
    run = 1'b1;
    tick();
    imem_ack = 1'b0;
    set_exp(S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_exp(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk_en = 1'b0;
    check("pre_rst_imem_req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_imem_req", 32'(imem_req), 32'd0);
    check("async_rst_pc",       32'(pc),       32'd0);
    check("async_rst_state",    32'(state_o),  32'(S_IDLE));
    release_reset();
    idle_until_run(1);

    // Straight-line ALU, then jump to 9.
    do_instr(0, 0, 1'b1, h);
    do_instr(0, 0, 1'b1, h);
    check("alu_retire_spacing", 32'(last_retire_cyc - prev_retire_cyc), 32'd5);
    do_instr(0, 0, 1'b1, h);
    check("alu_retire_spacing2", 32'(last_retire_cyc - prev_retire_cyc), 32'd5);
    do_instr(0, 0, 1'b1, h);
    check("jmp_target_addr", 32'(imem_addr), 32'd9);

    // Store with a 3-cycle dmem wait; run low at WB drops to IDLE.
    dmem_cycles = 0;
    do_instr(0, 3, 1'b0, h);
    check("store_latency",     32'(last_retire_cyc - prev_retire_cyc), 32'd9);
    check("store_dmem_cycles", 32'(dmem_cycles), 32'd4);
    check("idle_after_stop",   32'(state_o), 32'(S_IDLE));
    idle_until_run(2);

    // Jump to 15, then a no-op that wraps the PC to 0.
    do_instr(2, 0, 1'b1, h);
    do_instr(1, 0, 1'b1, h);
    check("wrap_fetch_addr", 32'(imem_addr), 32'd0);

    for (int a = 0; a < 16; a++) imem[a] = rand_instr();
    for (int n = 0; n < 150; n++) begin
      logic rw;
      rw = ($urandom_range(0, 3) != 0);
      do_instr(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
               int'($urandom_range(0, 3)), rw, h);
      if (!rw) idle_until_run(int'($urandom_range(0, 3)));
    end

    // Halt is sticky while run stays high.
    imem[m_pc] = 32'hF000_0000;
    do_instr(1, 0, 1'b1, h);
    for (int i = 0; i < 12; i++) begin
      run      = 1'b1;
      imem_ack = 1'($urandom);
      dmem_ack = 1'($urandom);
      garbage_dec();
      set_exp(S_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    check("halt_sticky",   32'(halted),   32'd1);
    check("halt_no_fetch", 32'(imem_req), 32'd0);

    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("halt_rst_halted", 32'(halted),  32'd0);
    check("halt_rst_state",  32'(state_o), 32'(S_IDLE));
    check("halt_rst_pc",     32'(pc),      32'd0);
    imem[0] = 32'h0100_0000;
    release_reset();
    idle_until_run(0);
    do_instr(0, 0, 1'b1, h);
    check("restart_next_addr", 32'(imem_addr), 32'd1);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
